// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer and the iterative divider beside it.
`timescale 1ns/1ps
package div_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} ctrl_state_e;

  // Divider-side state names, kept here so both sides of EX share one vocabulary.
  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the shared iterative divider: issues, stalls the pipe,
// holds a result across downstream stalls and drains the divider after an annul.
`timescale 1ns/1ps
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_req_i,
  input  logic             div_signed_i,
  input  logic [31:0]      op1_i,
  input  logic [31:0]      op2_i,
  input  logic             flush_i,
  input  logic             stall_i,
  output logic             stall_req_o,
  output logic             hilo_we_o,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic             div_start_o,
  output logic             div_annul_o,
  output logic             div_signed_o,
  output logic [31:0]      div_op1_o,
  output logic [31:0]      div_op2_o,
  input  logic [63:0]      div_result_i,
  input  logic             div_ready_i,
  output logic [CNT_W-1:0] div_count_o
);

  localparam int DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  ctrl_state_e        state_q, state_d;
  logic [31:0]        op1_q, op1_d;
  logic [31:0]        op2_q, op2_d;
  logic               signed_q, signed_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready;

  assign ready = (div_ready_i == DIV_RESULT_READY);

  // The divider samples operand signs again at its last step, so operands stay registered.
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign div_signed_o = signed_q;
  assign div_count_o  = count_q;

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    signed_d    = signed_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    drain_d     = drain_q;
    count_d     = count_q;
    stall_req_o = 1'b0;
    hilo_we_o   = 1'b0;
    hi_o        = 32'd0;
    lo_o        = 32'd0;
    div_start_o = DIV_STOP;
    div_annul_o = 1'b0;

    case (state_q)
      IDLE: begin
        stall_req_o = div_req_i & ~flush_i;
        if (div_req_i && !flush_i) begin
          op1_d    = op1_i;
          op2_d    = op2_i;
          signed_d = div_signed_i;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        div_start_o = ready ? DIV_STOP : DIV_START;
        stall_req_o = ~(ready & ~stall_i);
        if (flush_i) begin
          div_annul_o = 1'b1;
          div_start_o = DIV_STOP;
          drain_d     = DRAIN_W'(DRAIN_CYC);
          state_d     = DRAIN;
        end else if (ready && !stall_i) begin
          hilo_we_o = 1'b1;
          hi_o      = div_result_i[63:32];
          lo_o      = div_result_i[31:0];
          count_d   = count_q + CNT_W'(1);
          state_d   = IDLE;
        end else if (ready) begin
          // Start has dropped, so the divider frees itself next edge; keep our own copy.
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (!stall_i) begin
          hilo_we_o = 1'b1;
          hi_o      = hi_q;
          lo_o      = lo_q;
          count_d   = count_q + CNT_W'(1);
          state_d   = IDLE;
        end
      end

      DRAIN: begin
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q <= DRAIN_W'(1)) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      signed_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      drain_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      signed_q <= signed_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      drain_q  <= drain_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl with a cycle-accurate stand-in for the
// iterative divider and a transaction-level reference for results, latency and counts.
`timescale 1ns/1ps
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_req_i = 1'b0;
  logic        div_signed_i = 1'b0;
  logic [31:0] op1_i = 32'd0;
  logic [31:0] op2_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        stall_req_o, hilo_we_o, div_start_o, div_annul_o, div_signed_o;
  logic [31:0] hi_o, lo_o, div_op1_o, div_op2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic [31:0] div_count_o;

  int checks = 0;
  int passes = 0;
  int exp_count = 0;

  div_ctrl #(.CNT_W(32), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst(rst), .div_req_i(div_req_i), .div_signed_i(div_signed_i),
    .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i), .stall_i(stall_i),
    .stall_req_o(stall_req_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_result_i(div_result_i),
    .div_ready_i(div_ready_i), .div_count_o(div_count_o)
  );

  always #5 clk = ~clk;

  // MIPS divide semantics: truncating quotient, remainder takes the dividend's sign, x/0 gives 0.
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Divider stand-in: ready lands in the 4th (by-zero) or 36th cycle after issue,
  // computed from the operands the sequencer presents at that moment.
  div_state_e dstate;
  int         dcnt;
  always @(posedge clk) begin
    if (rst) begin
      dstate       <= DivFree;
      dcnt         <= 0;
      div_ready_i  <= DIV_RESULT_NOT_READY;
      div_result_i <= 64'd0;
    end else begin
      case (dstate)
        DivFree: begin
          if (div_start_o == DIV_START && !div_annul_o) begin
            dstate <= (div_op2_o == 32'd0) ? DivByZero : DivOn;
            dcnt   <= 1;
          end
        end
        DivByZero, DivOn: begin
          if (div_annul_o) begin
            dstate <= DivFree;
          end else if (dcnt == ((dstate == DivByZero) ? 2 : 34)) begin
            dstate       <= DivEnd;
            div_ready_i  <= DIV_RESULT_READY;
            div_result_i <= refDiv(div_op1_o, div_op2_o, div_signed_o);
          end else begin
            dcnt <= dcnt + 1;
          end
        end
        DivEnd: begin
          if (div_start_o == DIV_STOP || div_annul_o) begin
            dstate       <= DivFree;
            div_ready_i  <= DIV_RESULT_NOT_READY;
            div_result_i <= 64'd0;
          end
        end
        default: dstate <= DivFree;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [95:0] ctl();
    return 96'({stall_req_o, div_start_o, div_annul_o, hilo_we_o});
  endfunction

  // One DIV/DIVU transaction. Starts just after a rising edge, issues in that cycle.
  // flush_at: BUSY/HOLD cycle index carrying flush_i (0 = none).
  // stall_cyc: number of cycles stall_i is held, starting at the ready cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               input int flush_at, input int stall_cyc, input logic [31:0] garbage);
    int r, n;
    bit done;
    logic [63:0] exp_res;
    r = (b == 32'd0) ? 4 : 36;
    exp_res = refDiv(a, b, sgn);
    div_req_i = 1'b1; op1_i = a; op2_i = b; div_signed_i = sgn;
    flush_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    checkOutput("issue_ctl", ctl(), 96'(4'b1000));
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      n++;
      op1_i = garbage; op2_i = garbage ^ 32'h5a5a_5a5a; div_signed_i = ~sgn;
      flush_i = (n == flush_at);
      stall_i = (n >= r) && (n < r + stall_cyc);
      @(negedge clk);
      if (n < r) begin
        checkOutput("busy_ops", 96'({div_op1_o, div_op2_o, div_signed_o}), 96'({a, b, sgn}));
        if (flush_i) begin
          checkOutput("annul_ctl", ctl(), 96'(4'b1010));
          for (int d = 0; d < DRAIN; d++) begin
            @(posedge clk); #1;
            flush_i = 1'b0;
            @(negedge clk);
            checkOutput("drain_ctl", ctl(), 96'(4'b0000));
            checkOutput("drain_hilo", 96'({hi_o, lo_o}), 96'(0));
          end
          done = 1'b1;
        end else begin
          checkOutput("busy_ctl", ctl(), 96'(4'b1100));
          checkOutput("busy_hilo", 96'({hi_o, lo_o}), 96'(0));
        end
      end else if (n == r && stall_i) begin
        checkOutput("ready_stalled_ctl", ctl(), 96'(4'b1000));
        checkOutput("ready_stalled_hilo", 96'({hi_o, lo_o}), 96'(0));
      end else if (n > r && (flush_i || stall_i)) begin
        checkOutput("hold_ctl", ctl(), 96'(4'b0000));
        checkOutput("hold_hilo", 96'({hi_o, lo_o}), 96'(0));
        done = flush_i;
      end else begin
        checkOutput("write_ctl", ctl(), 96'(4'b0001));
        checkOutput("write_data", 96'({hi_o, lo_o}), 96'(exp_res));
        exp_count++;
        done = 1'b1;
      end
      if (n > 200) done = 1'b1;
    end
    @(posedge clk); #1;
    div_req_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    checkOutput("count", 96'(div_count_o), 96'(exp_count));
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          kind, r, sc, fa;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctl", ctl(), 96'(4'b0000));
    checkOutput("reset_data", 96'({hi_o, lo_o, div_signed_o}), 96'(0));
    checkOutput("reset_ops", 96'({div_op1_o, div_op2_o, div_count_o}), 96'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(32'd100, 32'd7, 1'b0, 0, 0, 32'h1234_5678);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, 32'd0);
    applyStimulus(32'd5, 32'd0, 1'b0, 0, 0, 32'hdead_beef);
    applyStimulus(32'd20, 32'd3, 1'b1, 10, 0, 32'h0bad_f00d);
    applyStimulus(32'd20, 32'd3, 1'b0, 0, 0, 32'h0000_0001);
    applyStimulus(32'd9, 32'd4, 1'b0, 0, 4, 32'hffff_ffff);
    applyStimulus(32'd17, 32'd0, 1'b0, 1, 0, 32'h0000_0003);
    applyStimulus(32'd8, 32'd2, 1'b0, 0, 0, 32'h7777_7777);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 32'h1);
    applyStimulus(32'd50, 32'd6, 1'b0, 38, 3, 32'h2);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 100);
        2: b = -$urandom_range(1, 100);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      r = (b == 32'd0) ? 4 : 36;
      kind = $urandom_range(0, 3);
      sc = 0;
      fa = 0;
      if (kind == 1) sc = $urandom_range(1, 4);
      if (kind == 2) fa = $urandom_range(1, r - 1);
      if (kind == 3) begin
        sc = $urandom_range(2, 4);
        fa = r + $urandom_range(1, sc);
      end
      applyStimulus(a, b, s, fa, sc, $urandom);
    end

    // Reset in the middle of a divide: no write, everything back to zero.
    div_req_i = 1'b1; op1_i = 32'd77; op2_i = 32'd5; div_signed_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; div_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 0;
    @(negedge clk);
    checkOutput("midop_reset_ctl", ctl(), 96'(4'b0000));
    checkOutput("midop_reset_state", 96'({div_op1_o, div_count_o, hi_o}), 96'(0));
    @(posedge clk); #1;
    applyStimulus(32'd63, 32'd8, 1'b0, 0, 0, 32'h4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- EX-stage sequencer for the shared 32-cycle iterative radix-2 divider (DIV/DIVU).
- Latches operands.
- Drives the divider's start/annul/signed/operand inputs.
- Raises a pipeline stall request while the divide runs.
- Delivers {HI=remainder, LO=quotient} as a one-cycle HI/LO write.
- Handles flush mid-operation, downstream stall at completion, and a drain period that returns the divider to its free state.

Parameters:
- CNT_W, 32, width of the completed-division counter.
- DRAIN_CYC, 2, cycles spent in DRAIN after an annul before a new request is accepted.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- div_req_i  in  1  a valid DIV/DIVU is in EX (level, held while stalled)
- div_signed_i  in  1  1 = DIV, 0 = DIVU
- op1_i  in  32  dividend
- op2_i  in  32  divisor
- flush_i  in  1  pipeline flush (exception/eret)
- stall_i  in  1  downstream stage holding the pipeline
- stall_req_o  out  1  request to stall IF/ID/EX
- hilo_we_o  out  1  HI/LO write strobe
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- div_start_o  out  1  divider start (1 = start, 0 = stop)
- div_annul_o  out  1  divider annul
- div_signed_o  out  1  divider signed select
- div_op1_o  out  32  divider dividend
- div_op2_o  out  32  divider divisor
- div_result_i  in  64  divider result {remainder, quotient}
- div_ready_i  in  1  divider result ready
- div_count_o  out  CNT_W  completed divisions (HI/LO writes), wraps

Behaviour:
- States: IDLE, BUSY, HOLD, DRAIN.
- Reset: state = IDLE; op/signed regs = 0; result regs = 0; drain counter = 0; div_count_o = 0. All outputs are 0 in the cycle after the reset edge.
- div_op1_o, div_op2_o and div_signed_o always come from registers latched at issue.
  - The divider re-reads operand signs at its final step, so these must stay stable for the whole operation.

IDLE:
- stall_req_o = div_req_i & ~flush_i.
- On div_req_i & ~flush_i: latch op1_i, op2_i and div_signed_i; go to BUSY.

BUSY:
- div_start_o = ~div_ready_i.
- stall_req_o = 1, except 0 when div_ready_i & ~stall_i.
- Priority: flush_i first, then div_ready_i.
- flush_i: div_annul_o = 1, div_start_o = 0, no write; go to DRAIN with counter = DRAIN_CYC.
- div_ready_i & ~stall_i: hilo_we_o = 1, hi_o = div_result_i[63:32], lo_o = div_result_i[31:0] (combinational pass-through); div_count_o + 1; go to IDLE.
- div_ready_i & stall_i: capture div_result_i into result regs; hilo_we_o = 0; go to HOLD.
- Start drops in the ready cycle, so the divider returns to free on the next edge.

HOLD:
- div_start_o = 0; hi_o/lo_o come from the result regs; stall_req_o = 0.
- flush_i: discard the result, go to IDLE.
- Else if ~stall_i: hilo_we_o = 1, div_count_o + 1, go to IDLE.

DRAIN:
- All divider controls are 0; stall_req_o = 0; div_req_i is ignored.
- Decrement the counter; go to IDLE when it reaches 1.
- This covers a flush landing in the divider's by-zero step: one cycle to its end state, one to free.

Timing and output rules:
- Nominal latency from the IDLE issue edge: div_ready_i arrives in BUSY cycle 36 for a non-zero divisor, cycle 4 for a zero divisor.
  - The block never counts; it always waits on div_ready_i.
- Divide by zero completes normally with hi = lo = 0; no exception is raised.
- Back-to-back divides: a new request can issue in the IDLE cycle right after a completion.
- hilo_we_o is never 1 in the same cycle as flush_i.
- hi_o and lo_o = 0 whenever hilo_we_o = 0.
- rst mid-operation returns the block to IDLE with no write. The divider shares rst.

Decomposition:
- Shared package (defines.h): state encodings IDLE/BUSY/HOLD/DRAIN next to DivFree/DivOn/DivByZero/DivEnd; DivStart/DivStop and DivResultReady/NotReady constants are reused.
- No sub-module: the block is one FSM plus its registers. It instantiates nothing; the divider sits beside it in EX.

Test Plan:
- DIVU 100/7, stall_i = 0 → stall_req_o high from issue until the ready cycle; one hilo_we_o pulse with lo = 14, hi = 2; div_count_o = 1.
- DIV 0xFFFFFFF9 (−7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. op1_i is changed to 0 after issue; the result is unchanged because operands are latched.
- DIVU 5/0 → ready in BUSY cycle 4; hilo_we_o with hi = lo = 0.
- DIV 20/3, flush_i in BUSY cycle 10 → div_annul_o pulses for 1 cycle, no write, DRAIN for 2 cycles. A following DIVU 20/3 gives lo = 6, hi = 2.
- DIVU 9/4 with stall_i = 1 at ready and for 3 more cycles → HOLD, no write. The write (lo = 2, hi = 1) happens in the first cycle with stall_i = 0.
- Flush in the first BUSY cycle of a DIVU x/0 → no write; DRAIN 2 cycles. The next DIVU 8/2 gives lo = 4, hi = 0 with correct latency.
